// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with busy scoreboard.
// Optional hardwired zero register and same-cycle write bypass.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic              rs_use_i,
  input  logic              rt_use_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic              hazard_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic [ADDR_W:0]   busy_cnt_o
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_ok, rsv_ok, inc, dec;
  logic rs_zero, rt_zero, rs_byp, rt_byp;

  assign wr_ok  = wr_en_i && !(ZR && wr_addr_i == '0);
  assign rsv_ok = rsv_en_i && !(ZR && rsv_addr_i == '0);

  // A write and reserve to the same register cancel in the count
  assign inc = rsv_ok && !busy_q[rsv_addr_i];
  assign dec = wr_ok && busy_q[wr_addr_i]
            && !(rsv_ok && rsv_addr_i == wr_addr_i);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr_i] = wr_data_i;
      busy_d[wr_addr_i] = 1'b0;
    end
    if (rsv_ok) busy_d[rsv_addr_i] = 1'b1;
    cnt_d = cnt_q
          + {{ADDR_W{1'b0}}, inc}
          - {{ADDR_W{1'b0}}, dec};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rs_zero = ZR && rs_addr_i == '0;
    rt_zero = ZR && rt_addr_i == '0;
    rs_byp  = BP && wr_ok && wr_addr_i == rs_addr_i;
    rt_byp  = BP && wr_ok && wr_addr_i == rt_addr_i;
    rs_data_o = rs_zero ? '0
              : rs_byp  ? wr_data_i
              : regs_q[rs_addr_i];
    rt_data_o = rt_zero ? '0
              : rt_byp  ? wr_data_i
              : regs_q[rt_addr_i];
    rs_busy_o = busy_q[rs_addr_i] && !rs_byp;
    rt_busy_o = busy_q[rt_addr_i] && !rt_byp;
    hazard_o  = (rs_use_i && rs_busy_o)
             || (rt_use_i && rt_busy_o);
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default instance plus
// a BYPASS=0 / ZERO_REG=0 instance sharing the same stimulus.
module tb_regfile_scoreboard;

  logic        clk = 0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, rsv_addr;
  logic        rs_use, rt_use, wr_en, rsv_en;
  logic [31:0] wr_data;

  logic [31:0] rs_data, rt_data, b_rs_data, b_rt_data;
  logic        rs_busy, rt_busy, hazard;
  logic        b_rs_busy, b_rt_busy, b_hazard;
  logic [5:0]  busy_cnt, b_busy_cnt;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk_i(clk), .rst_i(rst),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_use_i(rs_use), .rt_use_i(rt_use),
    .rs_data_o(rs_data), .rt_data_o(rt_data),
    .rs_busy_o(rs_busy), .rt_busy_o(rt_busy),
    .hazard_o(hazard),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
    .busy_cnt_o(busy_cnt)
  );

  regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_use_i(rs_use), .rt_use_i(rt_use),
    .rs_data_o(b_rs_data), .rt_data_o(b_rt_data),
    .rs_busy_o(b_rs_busy), .rt_busy_o(b_rt_busy),
    .hazard_o(b_hazard),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
    .busy_cnt_o(b_busy_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; rsv_en = 0;
    rs_use = 0; rt_use = 0;
    wr_addr = 0; wr_data = 0; rsv_addr = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      ntests++;
      if (rs_data !== 0 || rt_data !== 0 || rs_busy !== 0 ||
          rt_busy !== 0 || hazard !== 0 || busy_cnt !== 0) begin
        nfail++;
        $display("FAIL reset_state a=%0d rs=%h rt=%h bsy=%b%b hz=%b cnt=%0d want zeros",
                 i, rs_data, rt_data, rs_busy, rt_busy, hazard, busy_cnt);
      end
      ntests++;
      if (b_rs_data !== 0 || b_rt_data !== 0 || b_busy_cnt !== 0) begin
        nfail++;
        $display("FAIL reset_state_b a=%0d rs=%h rt=%h cnt=%0d want zeros",
                 i, b_rs_data, b_rt_data, b_busy_cnt);
      end
    end
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick();
    idle(); rs_addr = 5;
    #1;
    ntests++;
    if (rs_data !== 32'hDEADBEEF) begin
      nfail++;
      $display("FAIL r5_written got %h want deadbeef", rs_data);
    end
    do_reset();
    rs_addr = 5;
    #1;
    ntests++;
    if (rs_data !== 0 || b_rs_data !== 0) begin
      nfail++;
      $display("FAIL r5_after_reset got %h/%h want 0", rs_data, b_rs_data);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    rs_addr = 7; rt_addr = 7;
    wr_en = 1; wr_addr = 7; wr_data = 32'h12345678;
    #1;
    ntests++;
    if (rs_data !== 32'h12345678 || rt_data !== 32'h12345678) begin
      nfail++;
      $display("FAIL bypass_same_cycle got %h/%h want 12345678", rs_data, rt_data);
    end
    ntests++;
    if (b_rs_data !== 0) begin
      nfail++;
      $display("FAIL nobypass_old got %h want 0", b_rs_data);
    end
    tick();
    idle();
    #1;
    ntests++;
    if (b_rs_data !== 32'h12345678 || rs_data !== 32'h12345678) begin
      nfail++;
      $display("FAIL write_next_cycle got %h/%h want 12345678", b_rs_data, rs_data);
    end
  endtask

  task automatic test_zero();
    do_reset();
    rs_addr = 0; rt_addr = 0;
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1; rsv_addr = 0;
    #1;
    ntests++;
    if (rs_data !== 0) begin
      nfail++;
      $display("FAIL zero_bypass got %h want 0", rs_data);
    end
    tick();
    idle();
    #1;
    ntests++;
    if (rs_data !== 0 || rs_busy !== 0 || busy_cnt !== 0) begin
      nfail++;
      $display("FAIL zero_reg got d=%h b=%b c=%0d want 0/0/0", rs_data, rs_busy, busy_cnt);
    end
    ntests++;
    if (b_rs_data !== 32'hFFFFFFFF || b_rs_busy !== 1 || b_busy_cnt !== 1) begin
      nfail++;
      $display("FAIL r0_plain got d=%h b=%b c=%0d want ffffffff/1/1",
               b_rs_data, b_rs_busy, b_busy_cnt);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    rsv_en = 1; rsv_addr = 3; rs_addr = 3; rs_use = 1;
    #1;
    ntests++;
    if (hazard !== 0 || rs_busy !== 0) begin
      nfail++;
      $display("FAIL rsv_not_yet_visible got hz=%b b=%b want 0/0", hazard, rs_busy);
    end
    tick();
    idle(); rs_addr = 3; rs_use = 1;
    #1;
    ntests++;
    if (hazard !== 1 || rs_busy !== 1 || busy_cnt !== 1) begin
      nfail++;
      $display("FAIL rsv_hazard got hz=%b b=%b c=%0d want 1/1/1", hazard, rs_busy, busy_cnt);
    end
    rs_use = 0; rs_addr = 1; rt_addr = 3; rt_use = 1;
    #1;
    ntests++;
    if (hazard !== 1 || rt_busy !== 1) begin
      nfail++;
      $display("FAIL rt_hazard got hz=%b b=%b want 1/1", hazard, rt_busy);
    end
    rt_use = 0;
    #1;
    ntests++;
    if (hazard !== 0) begin
      nfail++;
      $display("FAIL hazard_unused got %b want 0", hazard);
    end
    rs_addr = 3; rs_use = 1;
    wr_en = 1; wr_addr = 3; wr_data = 32'hA5;
    #1;
    ntests++;
    if (hazard !== 0 || rs_busy !== 0 || rs_data !== 32'hA5) begin
      nfail++;
      $display("FAIL wb_bypass got hz=%b b=%b d=%h want 0/0/a5", hazard, rs_busy, rs_data);
    end
    ntests++;
    if (b_hazard !== 1) begin
      nfail++;
      $display("FAIL wb_nobypass_hz got %b want 1", b_hazard);
    end
    tick();
    idle(); rs_addr = 3; rs_use = 1;
    #1;
    ntests++;
    if (busy_cnt !== 0 || b_busy_cnt !== 0 || hazard !== 0 || b_hazard !== 0) begin
      nfail++;
      $display("FAIL wb_cleared got c=%0d/%0d hz=%b/%b want 0/0 0/0",
               busy_cnt, b_busy_cnt, hazard, b_hazard);
    end
  endtask

  task automatic test_waw();
    do_reset();
    rsv_en = 1; rsv_addr = 4;
    tick();
    idle();
    rsv_en = 1; rsv_addr = 4;
    wr_en = 1; wr_addr = 4; wr_data = 32'h44;
    tick();
    idle(); rs_addr = 4;
    #1;
    ntests++;
    if (rs_busy !== 1 || rs_data !== 32'h44 || busy_cnt !== 1) begin
      nfail++;
      $display("FAIL wr_rsv_same got b=%b d=%h c=%0d want 1/44/1", rs_busy, rs_data, busy_cnt);
    end
    rsv_en = 1; rsv_addr = 4;
    tick();
    idle();
    wr_en = 1; wr_addr = 6; wr_data = 32'h66;
    tick();
    idle(); rs_addr = 4; rt_addr = 6;
    #1;
    ntests++;
    if (busy_cnt !== 1 || rs_busy !== 1 || rt_data !== 32'h66 || rt_busy !== 0) begin
      nfail++;
      $display("FAIL waw_count got c=%0d b=%b d=%h rb=%b want 1/1/66/0",
               busy_cnt, rs_busy, rt_data, rt_busy);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i < 32; i++) begin
      rsv_en = 1; rsv_addr = 5'(i);
      tick();
    end
    idle();
    #1;
    ntests++;
    if (busy_cnt !== 31 || b_busy_cnt !== 31) begin
      nfail++;
      $display("FAIL fill_count got %0d/%0d want 31/31", busy_cnt, b_busy_cnt);
    end
    rsv_en = 1; rsv_addr = 0;
    tick();
    idle();
    #1;
    ntests++;
    if (busy_cnt !== 31 || b_busy_cnt !== 32) begin
      nfail++;
      $display("FAIL full_count got %0d/%0d want 31/32", busy_cnt, b_busy_cnt);
    end
    wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    rsv_en = 1; rsv_addr = 2;
    rst = 1;
    tick();
    idle(); rs_addr = 9; rt_addr = 2; rs_use = 1; rt_use = 1;
    #1;
    ntests++;
    if (rs_data !== 0 || rs_busy !== 0 || rt_busy !== 0 ||
        hazard !== 0 || busy_cnt !== 0) begin
      nfail++;
      $display("FAIL reset_inflight got d=%h b=%b%b hz=%b c=%0d want zeros",
               rs_data, rs_busy, rt_busy, hazard, busy_cnt);
    end
    ntests++;
    if (b_rs_data !== 0 || b_busy_cnt !== 0 || b_hazard !== 0) begin
      nfail++;
      $display("FAIL reset_inflight_b got d=%h c=%0d hz=%b want zeros",
               b_rs_data, b_busy_cnt, b_hazard);
    end
  endtask

  initial begin
    idle();
    rs_addr = 0; rt_addr = 0;
    rst = 1;
    test_reset();
    test_bypass();
    test_zero();
    test_hazard();
    test_waw();
    test_fill();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the CPU's two-read/one-write register file. Adds synchronous reset, a configurable hardwired zero register, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets the pipeline's hazard unit detect reads of registers with an outstanding writeback. The block sits between decode (reads and reservations) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, ≥2); ADDR_W = clog2(DEPTH)
- ZERO_REG, 1, 1 = register 0 always reads 0, is never written and is never busy
- BYPASS, 1, 1 = same-cycle writeback data and busy-clear are forwarded to the read ports

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- rs_addr_i  in  ADDR_W  read port A address
- rt_addr_i  in  ADDR_W  read port B address
- rs_use_i  in  1  port A operand is needed by the decoding instruction
- rt_use_i  in  1  port B operand is needed by the decoding instruction
- rs_data_o  out  DATA_W  port A data (combinational)
- rt_data_o  out  DATA_W  port B data (combinational)
- rs_busy_o  out  1  port A register has a pending writeback
- rt_busy_o  out  1  port B register has a pending writeback
- hazard_o  out  1  (rs_use_i & rs_busy_o) | (rt_use_i & rt_busy_o)
- wr_en_i  in  1  writeback strobe
- wr_addr_i  in  ADDR_W  writeback address
- wr_data_i  in  DATA_W  writeback data
- rsv_en_i  in  1  reserve destination register (instruction issued)
- rsv_addr_i  in  ADDR_W  register to reserve
- busy_cnt_o  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: DEPTH × DATA_W array plus DEPTH-bit busy vector.
- Write: on a rising edge with wr_en_i=1, store wr_data_i to register[wr_addr_i] and clear busy[wr_addr_i].
  - Ignored entirely when ZERO_REG=1 and wr_addr_i=0.
  - Writing a non-busy register is legal: data is stored and busy_cnt_o is unchanged.
- Reserve: on a rising edge with rsv_en_i=1, set busy[rsv_addr_i].
  - Ignored when ZERO_REG=1 and rsv_addr_i=0.
  - Reserving an already-busy register (WAW) leaves it busy; busy_cnt_o is unchanged.
- Simultaneous write and reserve to the same register: final busy=1 (the old reservation retires, the new one begins). Data is still written.
- Read data: register[addr]. Returns 0 when ZERO_REG=1 and addr=0.
  - With BYPASS=1 and wr_en_i=1, wr_addr_i==addr and addr not hardwired zero: output is wr_data_i.
- Busy outputs: busy[addr] from registered state.
  - With BYPASS=1, forced 0 when the same-cycle write matches addr.
  - A same-cycle reservation is not visible until the next cycle.
- busy_cnt_o: registered. Next value = current + (1 if a reservation sets a previously clear bit) − (1 if a write clears a previously set bit and that bit is not re-set the same cycle). Range 0..DEPTH, never wraps.
- Reset: rst_i=1 at an edge clears all registers to 0, the busy vector and busy_cnt_o. Reset overrides any same-cycle write or reserve.

## Timing
- Read latency: combinational from address, and from write inputs when BYPASS=1.
- Write-to-read: same cycle with BYPASS=1; next cycle with BYPASS=0.
- Reserve-to-busy: one cycle. Write-to-not-busy: same cycle with BYPASS=1, next cycle with BYPASS=0.
- Reset values of outputs after a reset edge: rs_data_o/rt_data_o=0, rs_busy_o/rt_busy_o=0, hazard_o=0, busy_cnt_o=0. These hold while addresses and strobes are idle.
- Reset asserted mid-operation discards all pending reservations; no writeback is required afterwards.

## Test plan
- Reset, then read all addresses → all data 0, busy 0, busy_cnt_o=0. Write 0xDEADBEEF to r5, then reset → r5 reads 0.
- BYPASS=1: wr r7=0x12345678 with rs_addr_i=7 in the same cycle → rs_data_o=0x12345678. BYPASS=0: old value this cycle, new value next cycle.
- ZERO_REG=1: write 0xFFFFFFFF to r0 and reserve r0 → r0 reads 0, busy 0, busy_cnt_o=0. ZERO_REG=0: r0 reads 0xFFFFFFFF.
- Reserve r3 → next cycle rs_addr_i=3 with rs_use_i=1 gives hazard_o=1 and busy_cnt_o=1. Writeback r3 (BYPASS=1) → hazard_o=0 that cycle, busy_cnt_o=0 next cycle.
- Reserve r4 and write r4 in the same cycle while r4 is busy → r4 stays busy, data updated, busy_cnt_o unchanged. Reserve an already-busy r4 → count unchanged.
- Reserve all DEPTH−1 non-zero registers → busy_cnt_o=DEPTH−1. Assert reset while a write is in flight → all cleared, written data discarded.
